// File: rtl/cla_mod_add_pipe.sv
// cla_mod_add_pipe
//   Three-stage pipelined modular adder, out = (a op b) mod MOD.
//     S1: bitwise propagate/generate (b inverted for subtract).
//     S2: carry lookahead. Each 16-bit block uses four 4-bit lookahead
//         groups under one group-lookahead level. Block carries ripple
//         between 16-bit blocks. S2 registers sum and carry-out.
//     S3: conditional modulus correction into the output register.
//   Each stage boundary uses a valid/ready handshake. A stage loads when it
//   is empty or when the stage after it loads or drains in the same cycle.
//   Backpressure therefore reaches in_ready combinationally from out_ready.
//
// Parameters
//   DATA_WIDTH  operand width, multiple of 16
//   the modulus parameter; operands must be below it
//
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   upstream handshake
//   in_a, in_b, in_op   operands; in_op 0=add 1=sub
//   out_valid/out_ready downstream handshake
//   out_sum             result in [0, MOD-1]
//
// Configuration macro
//   CLA_MOD_SUB_EN  when defined, in_op is honoured (subtract support).
//                   When undefined, the block only adds and in_op is unused.
module cla_mod_add_pipe #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] MOD        = 16'hFFF1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum
);

    localparam int NBLK = DATA_WIDTH / 16;

    // Returns the internal carries {c3,c2,c1} of a 4-bit lookahead group.
    function automatic logic [2:0] carry4(input logic [3:0] p, input logic [3:0] g,
                                          input logic ci);
        logic c1, c2, c3;
        c1 = g[0] | (ci & p[0]);
        c2 = g[1] | (g[0] & p[1]) | (ci & p[0] & p[1]);
        c3 = g[2] | (g[1] & p[2]) | (g[0] & p[1] & p[2]) | (ci & p[0] & p[1] & p[2]);
        return {c3, c2, c1};
    endfunction

    // Returns the group {generate, propagate} of a 4-bit lookahead group.
    function automatic logic [1:0] gp4(input logic [3:0] p, input logic [3:0] g);
        logic gg, pp;
        gg = g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3]);
        pp = &p;
        return {gg, pp};
    endfunction

    // vld_pipe[0] is the input valid; vld_pipe[k] is stage k occupancy.
    logic [3:1] vld_d, vld_q;
    logic [3:0] vld_pipe;
    logic       ld1, ld2, ld3;

    logic [DATA_WIDTH-1:0] p_d, p_q, g_d, g_q;
    logic [DATA_WIDTH-1:0] sum_d, sum_q;
    logic                  cout_d, cout_q;
    logic [DATA_WIDTH-1:0] out_d, out_q;

    logic [DATA_WIDTH-1:0] b_eff;
    logic                  c_in;
    logic [DATA_WIDTH:0]   carry;
    logic [3:0]            grp_g, grp_p, grp_c;
    logic [1:0]            blk_gp;
    logic [DATA_WIDTH-1:0] corr;
    logic [DATA_WIDTH:0]   sum_ext;

`ifdef CLA_MOD_SUB_EN
    logic op1_d, op1_q, op2_d, op2_q;
`else
    logic unused_op;
    assign unused_op = in_op;
`endif

    assign vld_pipe  = {vld_q, in_valid};
    assign in_ready  = ld1;
    assign out_valid = vld_q[3];
    assign out_sum   = out_q;

    // Handshake control: each stage can load when empty or when it is
    // being emptied this cycle.
    always_comb begin
        ld3   = !vld_q[3] | out_ready;
        ld2   = !vld_q[2] | ld3;
        ld1   = !vld_q[1] | ld2;
        vld_d = vld_q;
        if (ld1) vld_d[1] = vld_pipe[0];
        if (ld2) vld_d[2] = vld_pipe[1];
        if (ld3) vld_d[3] = vld_pipe[2];
    end

    // S1: propagate/generate.
    always_comb begin
`ifdef CLA_MOD_SUB_EN
        b_eff = in_op ? ~in_b : in_b;
        op1_d = op1_q;
        if (ld1 && in_valid) op1_d = in_op;
`else
        b_eff = in_b;
`endif
        p_d = p_q;
        g_d = g_q;
        if (ld1 && in_valid) begin
            p_d = in_a ^ b_eff;
            g_d = in_a & b_eff;
        end
    end

    // S2: two-level lookahead inside each 16-bit block. Carries between
    // blocks ripple.
    always_comb begin
`ifdef CLA_MOD_SUB_EN
        c_in = op1_q;
`else
        c_in = 1'b0;
`endif
        carry    = '0;
        carry[0] = c_in;
        grp_g    = '0;
        grp_p    = '0;
        grp_c    = '0;
        blk_gp   = '0;
        for (int k = 0; k < NBLK; k++) begin
            for (int j = 0; j < 4; j++)
                {grp_g[j], grp_p[j]} = gp4(p_q[16*k+4*j +: 4], g_q[16*k+4*j +: 4]);
            grp_c[0]   = carry[16*k];
            grp_c[3:1] = carry4(grp_p, grp_g, grp_c[0]);
            for (int j = 0; j < 4; j++) begin
                carry[16*k+4*j]       = grp_c[j];
                carry[16*k+4*j+1 +: 3] = carry4(p_q[16*k+4*j +: 4], g_q[16*k+4*j +: 4],
                                                grp_c[j]);
            end
            blk_gp          = gp4(grp_p, grp_g);
            carry[16*k+16]  = blk_gp[1] | (blk_gp[0] & grp_c[0]);
        end

        sum_d  = sum_q;
        cout_d = cout_q;
        if (ld2 && vld_q[1]) begin
            sum_d  = p_q ^ carry[DATA_WIDTH-1:0];
            cout_d = carry[DATA_WIDTH];
        end
`ifdef CLA_MOD_SUB_EN
        op2_d = op2_q;
        if (ld2 && vld_q[1]) op2_d = op1_q;
`endif
    end

    // S3: modulus correction. For add, a carry-out or sum >= MOD means the
    // true sum exceeds the modulus. For subtract, a missing carry-out is a
    // borrow, so MOD is added back.
    always_comb begin
        sum_ext = {cout_q, sum_q};
        corr    = sum_q;
`ifdef CLA_MOD_SUB_EN
        if (op2_q) begin
            if (!cout_q) corr = sum_q + MOD;
        end else if (sum_ext >= {1'b0, MOD}) begin
            corr = sum_q - MOD;
        end
`else
        if (sum_ext >= {1'b0, MOD}) corr = sum_q - MOD;
`endif
        out_d = out_q;
        if (ld3 && vld_q[2]) out_d = corr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            p_q    <= '0;
            g_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            out_q  <= '0;
`ifdef CLA_MOD_SUB_EN
            op1_q  <= 1'b0;
            op2_q  <= 1'b0;
`endif
        end else begin
            vld_q  <= vld_d;
            p_q    <= p_d;
            g_q    <= g_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            out_q  <= out_d;
`ifdef CLA_MOD_SUB_EN
            op1_q  <= op1_d;
            op2_q  <= op2_d;
`endif
        end
    end

endmodule

// File: tb/tb_cla_mod_add_pipe.sv
// Self-checking bench for cla_mod_add_pipe (DATA_WIDTH=16, MOD=0xFFF1).
module tb_cla_mod_add_pipe;

    localparam int MODV = 32'h0000_FFF1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;

    int tests_run = 0;
    int tests_failed = 0;

    cla_mod_add_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    // Samples the handshake, then advances to 1 time unit after the next rising edge.
    task automatic tick(output bit acc);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (out_sum !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_out_sum got %h want 0000", out_sum);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        bit acc;
        int n;
        out_ready = 1'b1;
        in_a = 16'h0001; in_b = 16'h0002; in_op = 1'b0; in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        tests_run++;
        if (acc !== 1'b1) begin
            tests_failed++; $display("FAIL basic_accept got %b want 1", acc);
        end
        n = 1;
        while (!out_valid && n < 10) begin
            tick(acc);
            n++;
        end
        tests_run++;
        if (n != 3) begin
            tests_failed++; $display("FAIL basic_latency got %0d want 3", n);
        end
        tests_run++;
        if (out_sum !== 16'h0003) begin
            tests_failed++; $display("FAIL basic_sum got %h want 0003", out_sum);
        end
        tick(acc);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_no_duplicate got %b want 0", out_valid);
        end
    endtask

    task automatic test_boundary;
        logic [15:0] va [4] = '{16'hFFF0, 16'hFFF0, 16'h0000, 16'hFFF0};
        logic [15:0] vb [4] = '{16'h0001, 16'hFFF0, 16'h0000, 16'h0000};
        logic [15:0] ve [4] = '{16'h0000, 16'hFFEF, 16'h0000, 16'hFFF0};
        bit acc;
        int idx = 0;
        int got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready && got < 4) begin
                tests_run++;
                if (out_sum !== ve[got]) begin
                    tests_failed++;
                    $display("FAIL boundary_%0d got %h want %h", got, out_sum, ve[got]);
                end
                got++;
            end
            if (idx < 4) begin
                in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx];
            end else in_valid = 1'b0;
            tick(acc);
            if (acc) idx++;
        end
        tests_run++;
        if (got != 4) begin
            tests_failed++; $display("FAIL boundary_count got %0d want 4", got);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] expq [$];
        logic [15:0] a, b, e;
        bit acc;
        int got = 0;
        int sent = 0;
        int gaps = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && got < 100; c++) begin
            if (got > 0 && !out_valid) gaps++;
            if (out_valid && out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                tests_run++;
                if (out_sum !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d got %h want %h", got, out_sum, e);
                end
                got++;
            end
            if (sent < 100) begin
                a = 16'($urandom_range(0, MODV - 1));
                b = 16'($urandom_range(0, MODV - 1));
                in_valid = 1'b1; in_a = a; in_b = b;
            end else in_valid = 1'b0;
            tick(acc);
            if (acc) begin
                expq.push_back(16'((32'(a) + 32'(b)) % MODV));
                sent++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != 100) begin
            tests_failed++; $display("FAIL b2b_count got %0d want 100", got);
        end
        tests_run++;
        if (gaps != 0) begin
            tests_failed++; $display("FAIL b2b_gaps got %0d want 0", gaps);
        end
    endtask

    task automatic test_stall;
        logic [15:0] va [6] = '{16'h0010, 16'h8000, 16'hFFF0, 16'h1234, 16'h7FFF, 16'h0000};
        logic [15:0] vb [6] = '{16'h0020, 16'h8000, 16'h0005, 16'h4321, 16'h7FF2, 16'h0000};
        logic [15:0] ve [6] = '{16'h0030, 16'h000F, 16'h0004, 16'h5555, 16'h0000, 16'h0000};
        bit acc;
        int idx = 0;
        int got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) begin
                tests_run++;
                if (out_sum !== ve[0]) begin
                    tests_failed++;
                    $display("FAIL stall_hold_%0d got %h want %h", c, out_sum, ve[0]);
                end
            end
            in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx];
            tick(acc);
            if (acc) idx++;
        end
        tests_run++;
        if (idx != 3) begin
            tests_failed++; $display("FAIL stall_accepts got %0d want 3", idx);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL stall_in_ready got %b want 0", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== ve[0]) begin
            tests_failed++;
            $display("FAIL stall_out got v=%b %h want v=1 %h", out_valid, out_sum, ve[0]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready && got < 6) begin
                tests_run++;
                if (out_sum !== ve[got]) begin
                    tests_failed++;
                    $display("FAIL stall_drain_%0d got %h want %h", got, out_sum, ve[got]);
                end
                got++;
            end
            if (idx < 6) begin
                in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx];
            end else in_valid = 1'b0;
            tick(acc);
            if (acc) idx++;
        end
        tests_run++;
        if (got != 6) begin
            tests_failed++; $display("FAIL stall_count got %0d want 6", got);
        end
    endtask

    task automatic test_reset_midflight;
        bit acc;
        int stale = 0;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'(16'h0100 * (i + 1)); in_b = 16'h0011;
            tick(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (out_sum !== 16'h0000) begin
            tests_failed++; $display("FAIL rst_mid_out_sum got %h want 0000", out_sum);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(acc);
            if (out_valid) stale++;
        end
        tests_run++;
        if (stale != 0) begin
            tests_failed++; $display("FAIL rst_mid_stale got %0d want 0", stale);
        end
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0001;
        tick(acc);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick(acc);
            n++;
        end
        tests_run++;
        if (n != 3 || out_sum !== 16'h1235) begin
            tests_failed++;
            $display("FAIL rst_mid_new got lat=%0d %h want lat=3 1235", n, out_sum);
        end
        tick(acc);
    endtask

`ifdef CLA_MOD_SUB_EN
    task automatic test_sub;
        logic [15:0] va [3] = '{16'h0002, 16'h0005, 16'h0003};
        logic [15:0] vb [3] = '{16'h0005, 16'h0002, 16'h0004};
        logic        vo [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] ve [3] = '{16'hFFEE, 16'h0003, 16'h0007};
        bit acc;
        int idx = 0;
        int got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (out_valid && out_ready && got < 3) begin
                tests_run++;
                if (out_sum !== ve[got]) begin
                    tests_failed++;
                    $display("FAIL sub_%0d got %h want %h", got, out_sum, ve[got]);
                end
                got++;
            end
            if (idx < 3) begin
                in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx]; in_op = vo[idx];
            end else begin
                in_valid = 1'b0; in_op = 1'b0;
            end
            tick(acc);
            if (acc) idx++;
        end
        tests_run++;
        if (got != 3) begin
            tests_failed++; $display("FAIL sub_count got %0d want 3", got);
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_basic();
        test_boundary();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef CLA_MOD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
